// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding.
// Feeds ALU operands A/B and ALUCode, and passes store data and controls on.
// Optional macro LOAD_USE_DETECT_EN enables combinational load-use detection;
// without it load_use_hazard is tied low.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alu_code,
  input  logic              id_alu_src_a,
  input  logic              id_alu_src_b,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [DATA_W-1:0] exm_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_code,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              load_use_hazard
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
  logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [3:0]        alu_code_q, alu_code_d;
  logic              src_a_q, src_a_d;
  logic              src_b_q, src_b_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic [DATA_W-1:0] fwd_rs1;
  logic [DATA_W-1:0] fwd_rs2;

  // Bypass network: EX/MEM beats MEM/WB, and x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exm_reg_write && (exm_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = exm_result;
    else if (wb_reg_write && (wb_rd == rs1_q) && (rs1_q != '0))
      fwd_rs1 = wb_result;

    fwd_rs2 = rs2_data_q;
    if (exm_reg_write && (exm_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = exm_result;
    else if (wb_reg_write && (wb_rd == rs2_q) && (rs2_q != '0))
      fwd_rs2 = wb_result;
  end

  // Next-state for the ID/EX register: flush > stall > normal load.
  // While stalled, the operand data registers absorb the forwarded values so
  // a producer that retires during the stall is not lost.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_code_d  = alu_code_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_code_d  = '0;
      src_a_d     = 1'b0;
      src_b_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (stall) begin
      rs1_data_d = fwd_rs1;
      rs2_data_d = fwd_rs2;
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      alu_code_d  = id_alu_code;
      src_a_d     = id_alu_src_a;
      src_b_d     = id_alu_src_b;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  // ID/EX register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_code_q  <= '0;
      src_a_q     <= 1'b0;
      src_b_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_code_q  <= alu_code_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign alu_a        = src_a_q ? pc_q : fwd_rs1;
  assign alu_b        = src_b_q ? imm_q : fwd_rs2;
  assign store_data   = fwd_rs2;
  assign alu_code     = alu_code_q;
  assign ex_rd        = rd_q;
  assign ex_valid     = valid_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;

`ifdef LOAD_USE_DETECT_EN
  assign load_use_hazard = mem_read_q & valid_q & (rd_q != '0) &
                           ((rd_q == id_rs1) | (rd_q == id_rs2));
`else
  assign load_use_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed testbench for id_ex_operand_stage.
module tb_id_ex_operand_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset, stall, flush, id_valid;
  logic [DATA_W-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]        id_alu_code;
  logic              id_alu_src_a, id_alu_src_b;
  logic              id_reg_write, id_mem_read, id_mem_write;
  logic [REG_AW-1:0] exm_rd, wb_rd;
  logic              exm_reg_write, wb_reg_write;
  logic [DATA_W-1:0] exm_result, wb_result;
  logic [DATA_W-1:0] alu_a, alu_b, store_data;
  logic [3:0]        alu_code;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic              load_use_hazard;

  int nvec = 0;
  int nerr = 0;
  logic exp_hz;

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_code(id_alu_code),
    .id_alu_src_a(id_alu_src_a), .id_alu_src_b(id_alu_src_b),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .store_data(store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with every input nonzero.
    reset = 1; stall = 0; flush = 0; id_valid = 1;
    id_pc = 32'h400; id_rs1_data = 32'h1111; id_rs2_data = 32'h2222;
    id_imm = 32'h3333; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_alu_code = 4'd7; id_alu_src_a = 0; id_alu_src_b = 1;
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    exm_rd = 5'd9; exm_reg_write = 1; exm_result = 32'h55;
    wb_rd = 5'd10; wb_reg_write = 1; wb_result = 32'h66;
    step();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_memrd", {31'd0, ex_mem_read}, 32'd0);
    chk("rst_code", {28'd0, alu_code}, 32'd0);
    chk("rst_rd", {27'd0, ex_rd}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    // Plain capture.
    reset = 0; exm_reg_write = 0; wb_reg_write = 0;
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4; id_rs1_data = 32'd5;
    id_rs2_data = 32'd9; id_imm = 32'd7; id_alu_src_a = 0; id_alu_src_b = 1;
    id_alu_code = 4'd0; id_mem_read = 0; id_mem_write = 0;
    step();
    chk("cap_alu_a", alu_a, 32'd5);
    chk("cap_alu_b", alu_b, 32'd7);
    chk("cap_code", {28'd0, alu_code}, 32'd0);
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("cap_rd", {27'd0, ex_rd}, 32'd4);
    chk("cap_store", store_data, 32'd9);

    // PC as operand A, sltu code, rs2 as operand B.
    id_alu_src_a = 1; id_alu_src_b = 0; id_pc = 32'h100; id_alu_code = 4'd10;
    step();
    chk("pc_alu_a", alu_a, 32'h100);
    chk("pc_alu_b", alu_b, 32'd9);
    chk("pc_code", {28'd0, alu_code}, 32'd10);

    // Double forward: EX/MEM beats MEM/WB, then MEM/WB, then register.
    id_alu_src_a = 0; id_rs1 = 5'd3; id_rs1_data = 32'h33; id_alu_code = 4'd0;
    exm_rd = 5'd3; exm_result = 32'h11; exm_reg_write = 1;
    wb_rd = 5'd3; wb_result = 32'h22; wb_reg_write = 1;
    step();
    chk("fwd_exm", alu_a, 32'h11);
    exm_reg_write = 0; #1;
    chk("fwd_wb", alu_a, 32'h22);
    wb_reg_write = 0; #1;
    chk("fwd_none", alu_a, 32'h33);

    // x0 guard on rs2.
    id_rs2 = 5'd0; id_rs2_data = 32'd0; id_alu_src_b = 0;
    exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'hFF;
    wb_rd = 5'd0; wb_reg_write = 1; wb_result = 32'hEE;
    step();
    chk("x0_store", store_data, 32'd0);
    chk("x0_alu_b", alu_b, 32'd0);

    // Stall capture of a result retiring during the stall.
    exm_reg_write = 0; wb_reg_write = 0;
    id_rs1 = 5'd6; id_rs1_data = 32'h10; id_rd = 5'd7; id_alu_code = 4'd3;
    step();
    chk("st_pre_a", alu_a, 32'h10);
    stall = 1; wb_rd = 5'd6; wb_result = 32'hABCD; wb_reg_write = 1;
    id_rs1_data = 32'h99; id_rd = 5'd8; id_alu_code = 4'd5;
    step();
    wb_reg_write = 0; #1;
    chk("st1_alu_a", alu_a, 32'hABCD);
    chk("st1_rd", {27'd0, ex_rd}, 32'd7);
    chk("st1_code", {28'd0, alu_code}, 32'd3);
    step();
    chk("st2_alu_a", alu_a, 32'hABCD);
    stall = 0; #1;
    chk("st_rel_a", alu_a, 32'hABCD);
    step();
    chk("ld_alu_a", alu_a, 32'h99);
    chk("ld_rd", {27'd0, ex_rd}, 32'd8);
    chk("ld_code", {28'd0, alu_code}, 32'd5);

    // Flush and stall together give a bubble.
    stall = 1; flush = 1;
    step();
    chk("fl_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_rd", {27'd0, ex_rd}, 32'd0);
    chk("fl_code", {28'd0, alu_code}, 32'd0);
    chk("fl_alu_a", alu_a, 32'd0);

    // Load-use detection: EX holds lw x5.
    stall = 0; flush = 0; id_valid = 1; id_mem_read = 1; id_rd = 5'd5;
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    step();
    chk("lu_memrd", {31'd0, ex_mem_read}, 32'd1);
    id_rs1 = 5'd1; id_rs2 = 5'd5; #1;
`ifdef LOAD_USE_DETECT_EN
    exp_hz = 1'b1;
`else
    exp_hz = 1'b0;
`endif
    chk("lu_hit", {31'd0, load_use_hazard}, {31'd0, exp_hz});
    id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    chk("lu_x0", {31'd0, load_use_hazard}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
